// File: rtl/merge_a4.sv
// merge_a4: 4-way dual-rail merge. This is the collecting end of a 4-way steer.
// A one-hot select forwards one of S/T/U/V onto A. The select code is
// forwarded on steerout. The block runs the NCL DATA/NULL wave handshake
// synchronously, so every output comes from a register.
module merge_a4 #(
   parameter int W = 1
) (
   input  logic           clk,
   input  logic           init,
   input  logic [2*W-1:0] Ss,
   output logic           SCOMP,
   input  logic [2*W-1:0] Ts,
   output logic           TCOMP,
   input  logic [2*W-1:0] Us,
   output logic           UCOMP,
   input  logic [2*W-1:0] Vs,
   output logic           VCOMP,
   input  logic [3:0]     steerin,
   output logic           steerinCOMP,
   output logic [2*W-1:0] A,
   input  logic           ACOMP,
   output logic [3:0]     steerout,
   input  logic           steeroutCOMP,
   output logic           proto_err
);

   typedef enum logic {WAIT_DATA, HOLD} state_t;

   state_t         state_q, state_d;
   logic [2*W-1:0] a_q, a_d;
   logic [3:0]     steer_q, steer_d;
   logic [3:0]     comp_q, comp_d;
   logic           sinc_q, sinc_d;
   logic           err_q, err_d;

   logic [3:0][2*W-1:0] ch;
   logic [3:0]          mask;
   logic [2*W-1:0]      sel;
   logic                sel_cmp, sel_bad, sel_null;
   logic                s_null, s_onehot, s_multi, err_now;

   assign ch = {Vs, Us, Ts, Ss};

   // A channel is complete when every rail pair has at least one rail high.
   function automatic logic is_complete(input logic [2*W-1:0] x);
      logic r;
      r = 1'b1;
      for (int i = 0; i < W; i++) r &= x[2*i] | x[2*i+1];
      return r;
   endfunction

   // Both rails of one pair high is an illegal dual-rail code.
   function automatic logic has_both(input logic [2*W-1:0] x);
      logic r;
      r = 1'b0;
      for (int i = 0; i < W; i++) r |= x[2*i] & x[2*i+1];
      return r;
   endfunction

   // Select the channel: live steerin while waiting, the latched code while holding.
   always_comb begin
      mask = (state_q == HOLD) ? steer_q : steerin;
      sel  = '0;
      for (int k = 0; k < 4; k++)
         if (mask[k]) sel |= ch[k];
      sel_cmp  = is_complete(sel) && !has_both(sel);
      sel_bad  = has_both(sel);
      sel_null = (sel == '0);
      s_null   = (steerin == 4'b0000);
      s_multi  = ((steerin & (steerin - 4'd1)) != 4'b0000);
      s_onehot = !s_null && !s_multi;
      err_now  = s_multi || sel_bad ||
                 (state_q == HOLD && s_onehot && steerin != steer_q) ||
                 (state_q == HOLD && sel_cmp && sel != a_q);
   end

   // Next-state logic. Capture and release are both blocked while an error is present.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      steer_d = steer_q;
      comp_d  = comp_q;
      sinc_d  = sinc_q;
      err_d   = err_q | err_now;
      case (state_q)
         WAIT_DATA: begin
            if (!err_now && s_onehot && sel_cmp && !ACOMP && !steeroutCOMP) begin
               a_d     = sel;
               steer_d = steerin;
               comp_d  = steerin;
               sinc_d  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!err_now && ACOMP && steeroutCOMP && s_null && sel_null) begin
               a_d     = '0;
               steer_d = '0;
               comp_d  = '0;
               sinc_d  = 1'b0;
               state_d = WAIT_DATA;
            end
         end
         default: state_d = WAIT_DATA;
      endcase
   end

   // State and output registers. init overrides every other event.
   always_ff @(posedge clk) begin
      if (init) begin
         state_q <= WAIT_DATA;
         a_q     <= '0;
         steer_q <= '0;
         comp_q  <= '0;
         sinc_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         steer_q <= steer_d;
         comp_q  <= comp_d;
         sinc_q  <= sinc_d;
         err_q   <= err_d;
      end
   end

   assign A           = a_q;
   assign steerout    = steer_q;
   assign SCOMP       = comp_q[0];
   assign TCOMP       = comp_q[1];
   assign UCOMP       = comp_q[2];
   assign VCOMP       = comp_q[3];
   assign steerinCOMP = sinc_q;
   assign proto_err   = err_q;

endmodule

// File: tb/tb_merge_a4.sv
// Directed bench for merge_a4, using a W=1 instance (u1) and a W=2 instance (u2).
module tb_merge_a4;

   logic clk = 1'b0;
   logic init;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // W=1 instance signals
   logic [1:0] Ss, Ts, Us, Vs, A;
   logic [3:0] steerin, steerout;
   logic ACOMP, steeroutCOMP, SCOMP, TCOMP, UCOMP, VCOMP, steerinCOMP, proto_err;

   // W=2 instance signals
   logic [3:0] Ss2, Ts2, Us2, Vs2, A2;
   logic [3:0] steerin2, steerout2;
   logic ACOMP2, steeroutCOMP2, SCOMP2, TCOMP2, UCOMP2, VCOMP2, steerinCOMP2, proto_err2;

   merge_a4 #(.W(1)) u1 (
      .clk(clk), .init(init),
      .Ss(Ss), .SCOMP(SCOMP), .Ts(Ts), .TCOMP(TCOMP),
      .Us(Us), .UCOMP(UCOMP), .Vs(Vs), .VCOMP(VCOMP),
      .steerin(steerin), .steerinCOMP(steerinCOMP),
      .A(A), .ACOMP(ACOMP), .steerout(steerout), .steeroutCOMP(steeroutCOMP),
      .proto_err(proto_err));

   merge_a4 #(.W(2)) u2 (
      .clk(clk), .init(init),
      .Ss(Ss2), .SCOMP(SCOMP2), .Ts(Ts2), .TCOMP(TCOMP2),
      .Us(Us2), .UCOMP(UCOMP2), .Vs(Vs2), .VCOMP(VCOMP2),
      .steerin(steerin2), .steerinCOMP(steerinCOMP2),
      .A(A2), .ACOMP(ACOMP2), .steerout(steerout2), .steeroutCOMP(steeroutCOMP2),
      .proto_err(proto_err2));

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Packed view of u1 outputs: {A, steerout, S/T/U/V COMP, steerinCOMP, proto_err}
   function automatic logic [12:0] st1();
      return {A, steerout, SCOMP, TCOMP, UCOMP, VCOMP, steerinCOMP, proto_err};
   endfunction

   task automatic test_reset();
      init = 1'b1;
      tick();
      init = 1'b0;
      checks++;
      if (st1() !== 13'b0) begin
         errors++; $display("FAIL reset_u1 got %b want %b", st1(), 13'b0);
      end
      checks++;
      if ({A2, steerout2, TCOMP2, steerinCOMP2, proto_err2} !== 11'b0) begin
         errors++; $display("FAIL reset_u2 got A=%b so=%b", A2, steerout2);
      end
   endtask

   task automatic test_capture_u();
      Us = 2'b10; steerin = 4'b0100;
      tick();
      checks++;
      if (st1() !== {2'b10, 4'b0100, 4'b0010, 1'b1, 1'b0}) begin
         errors++; $display("FAIL capture_u got %b want %b", st1(), {2'b10, 4'b0100, 4'b0010, 1'b1, 1'b0});
      end
   endtask

   task automatic test_release_order();
      logic [12:0] held;
      held = {2'b10, 4'b0100, 4'b0010, 1'b1, 1'b0};
      ACOMP = 1'b1; tick(2);
      checks++;
      if (st1() !== held) begin errors++; $display("FAIL hold_acomp got %b want %b", st1(), held); end
      Us = 2'b00; tick(2);
      checks++;
      if (st1() !== held) begin errors++; $display("FAIL hold_unull got %b want %b", st1(), held); end
      steerin = 4'b0000; tick(2);
      checks++;
      if (st1() !== held) begin errors++; $display("FAIL hold_snull got %b want %b", st1(), held); end
      steeroutCOMP = 1'b1; tick();
      checks++;
      if (st1() !== 13'b0) begin errors++; $display("FAIL release got %b want %b", st1(), 13'b0); end
      ACOMP = 1'b0; steeroutCOMP = 1'b0; tick();
   endtask

   task automatic test_stall();
      ACOMP = 1'b1; Ss = 2'b01; steerin = 4'b0001;
      tick(3);
      checks++;
      if ({A, SCOMP, steerinCOMP} !== 4'b0000) begin
         errors++; $display("FAIL stall got A=%b SCOMP=%b want 00 0", A, SCOMP);
      end
      ACOMP = 1'b0; tick();
      checks++;
      if ({A, steerout, SCOMP, steerinCOMP} !== {2'b01, 4'b0001, 1'b1, 1'b1}) begin
         errors++; $display("FAIL stall_cap got A=%b so=%b SCOMP=%b want 01 0001 1", A, steerout, SCOMP);
      end
      Ss = 2'b00; steerin = 4'b0000; ACOMP = 1'b1; steeroutCOMP = 1'b1; tick();
      checks++;
      if (st1() !== 13'b0) begin errors++; $display("FAIL stall_rel got %b want %b", st1(), 13'b0); end
      ACOMP = 1'b0; steeroutCOMP = 1'b0; tick();
   endtask

   task automatic test_unselected();
      // Unselected channels with data (including both-rails-high) are ignored.
      Ts = 2'b11; Vs = 2'b10; Us = 2'b01; steerin = 4'b0000;
      tick(2);
      checks++;
      if (st1() !== 13'b0) begin errors++; $display("FAIL unsel_null got %b want %b", st1(), 13'b0); end
      Ss = 2'b10; steerin = 4'b0001; tick();
      checks++;
      if (st1() !== {2'b10, 4'b0001, 4'b1000, 1'b1, 1'b0}) begin
         errors++; $display("FAIL unsel_cap got %b want %b", st1(), {2'b10, 4'b0001, 4'b1000, 1'b1, 1'b0});
      end
      Ss = 2'b00; Ts = 2'b00; Us = 2'b00; Vs = 2'b00; steerin = 4'b0000;
      ACOMP = 1'b1; steeroutCOMP = 1'b1; tick();
      ACOMP = 1'b0; steeroutCOMP = 1'b0; tick();
   endtask

   task automatic test_partial_w2();
      Ts2 = 4'b1000; steerin2 = 4'b0010;
      tick(3);
      checks++;
      if ({A2, TCOMP2} !== 5'b0) begin errors++; $display("FAIL partial got A2=%b TCOMP2=%b want 0000 0", A2, TCOMP2); end
      Ts2 = 4'b1001; tick();
      checks++;
      if ({A2, steerout2, TCOMP2, SCOMP2, steerinCOMP2} !== {4'b1001, 4'b0010, 1'b1, 1'b0, 1'b1}) begin
         errors++; $display("FAIL w2_cap got A2=%b so=%b TCOMP2=%b want 1001 0010 1", A2, steerout2, TCOMP2);
      end
      // Changing to a different complete value while held is an error; outputs stay put.
      Ts2 = 4'b0110; tick();
      checks++;
      if ({proto_err2, A2, TCOMP2} !== {1'b1, 4'b1001, 1'b1}) begin
         errors++; $display("FAIL hold_chg got err=%b A2=%b want 1 1001", proto_err2, A2);
      end
      Ts2 = 4'b0000; steerin2 = 4'b0000; ACOMP2 = 1'b1; steeroutCOMP2 = 1'b1; tick();
      checks++;
      if ({proto_err2, A2, TCOMP2, steerinCOMP2} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
         errors++; $display("FAIL w2_rel got err=%b A2=%b TCOMP2=%b want 1 0000 0", proto_err2, A2, TCOMP2);
      end
      ACOMP2 = 1'b0; steeroutCOMP2 = 1'b0;
   endtask

   task automatic test_error();
      Ss = 2'b01; steerin = 4'b0011;
      tick();
      checks++;
      if ({proto_err, A, SCOMP, TCOMP, steerinCOMP} !== {1'b1, 2'b00, 3'b000}) begin
         errors++; $display("FAIL multihot got err=%b A=%b SCOMP=%b want 1 00 0", proto_err, A, SCOMP);
      end
      steerin = 4'b0001; tick();
      checks++;
      if ({proto_err, A, SCOMP, steerinCOMP} !== {1'b1, 2'b01, 1'b1, 1'b1}) begin
         errors++; $display("FAIL err_resume got err=%b A=%b SCOMP=%b want 1 01 1", proto_err, A, SCOMP);
      end
      init = 1'b1; tick(); init = 1'b0;
      checks++;
      if (st1() !== 13'b0) begin errors++; $display("FAIL err_init got %b want %b", st1(), 13'b0); end
      Ss = 2'b00; steerin = 4'b0000; tick();
   endtask

   task automatic test_reset_midwave();
      Vs = 2'b01; steerin = 4'b1000;
      tick();
      checks++;
      if ({VCOMP, A} !== 3'b101) begin errors++; $display("FAIL mid_cap got VCOMP=%b A=%b want 1 01", VCOMP, A); end
      init = 1'b1; tick();
      checks++;
      if ({A, VCOMP, steerout, steerinCOMP} !== 8'b0) begin
         errors++; $display("FAIL mid_init got A=%b VCOMP=%b so=%b want 00 0 0000", A, VCOMP, steerout);
      end
      init = 1'b0; Vs = 2'b10; tick();
      checks++;
      if (st1() !== {2'b10, 4'b1000, 4'b0001, 1'b1, 1'b0}) begin
         errors++; $display("FAIL mid_fresh got %b want %b", st1(), {2'b10, 4'b1000, 4'b0001, 1'b1, 1'b0});
      end
   endtask

   initial begin
      init = 1'b0;
      Ss = '0; Ts = '0; Us = '0; Vs = '0; steerin = '0; ACOMP = 1'b0; steeroutCOMP = 1'b0;
      Ss2 = '0; Ts2 = '0; Us2 = '0; Vs2 = '0; steerin2 = '0; ACOMP2 = 1'b0; steeroutCOMP2 = 1'b0;
      #2;
      test_reset();
      test_capture_u();
      test_release_order();
      test_stall();
      test_unselected();
      test_partial_w2();
      test_error();
      test_reset_midwave();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
